// File: rtl/operand_fetch.sv
// operand_fetch
//   Register-read stage sitting between decode and execute.
//   - Reads rs1/rs2 through the combinational regfile read ports and forwards
//     same-cycle writeback data over the regfile value.
//   - Keeps a busy-bit scoreboard of destinations still waiting for writeback
//     and stalls decode on RAW (source busy) and WAW (destination busy) hazards.
//   - Holds a single registered output slot for execute.
//
// Handshakes (both sides, valid/ready):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer keeps valid and its payload stable until that transfer.
//   ready may depend combinationally on the consumer's state, and it is never
//   derived from valid. On the decode side id_ready is computed here. On the
//   execute side ex_ready comes from execute and is ignored while ex_valid=0.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_*                       instruction from decode (valid/ready)
//   rf_rs1_*/rf_rs2_*          regfile read ports (index out, data in)
//   wb_we/wb_rd_idx/wb_rd_data writeback port (also drives the regfile)
//   flush                      squash this stage and clear the scoreboard
//   ex_*                       registered operands to execute (valid/ready)
//   dbg_busy                   scoreboard busy bits, for observation only
module operand_fetch #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 3,
  parameter int OP_W      = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [REG_IDX_W-1:0]      id_rs1_idx,
  input  logic                      id_rs1_en,
  input  logic [REG_IDX_W-1:0]      id_rs2_idx,
  input  logic                      id_rs2_en,
  input  logic [REG_IDX_W-1:0]      id_rd_idx,
  input  logic                      id_rd_we,
  input  logic [XLEN-1:0]           id_imm,
  input  logic [OP_W-1:0]           id_op,
  output logic [REG_IDX_W-1:0]      rf_rs1_idx,
  input  logic [XLEN-1:0]           rf_rs1_data,
  output logic [REG_IDX_W-1:0]      rf_rs2_idx,
  input  logic [XLEN-1:0]           rf_rs2_data,
  input  logic                      wb_we,
  input  logic [REG_IDX_W-1:0]      wb_rd_idx,
  input  logic [XLEN-1:0]           wb_rd_data,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [XLEN-1:0]           ex_rs1_data,
  output logic [XLEN-1:0]           ex_rs2_data,
  output logic [REG_IDX_W-1:0]      ex_rd_idx,
  output logic                      ex_rd_we,
  output logic [XLEN-1:0]           ex_imm,
  output logic [OP_W-1:0]           ex_op,
  output logic [(2**REG_IDX_W)-1:0] dbg_busy
);

  localparam int REG_COUNT = 2 ** REG_IDX_W;

  // Output slot: EMPTY means ex_valid=0, FULL means ex_valid=1.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t          state;
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;

  logic                 fwd1, fwd2;
  logic [XLEN-1:0]      op1, op2;
  logic                 haz1, haz2, haz_w;
  logic                 wb_hits_rd;
  logic                 accept;

  assign rf_rs1_idx = id_rs1_idx;
  assign rf_rs2_idx = id_rs2_idx;

  // Writeback to r0 never forwards: r0 always reads as zero.
  assign fwd1 = wb_we && (wb_rd_idx != '0) && (wb_rd_idx == id_rs1_idx);
  assign fwd2 = wb_we && (wb_rd_idx != '0) && (wb_rd_idx == id_rs2_idx);

  assign op1 = (id_rs1_idx == '0) ? '0 : (fwd1 ? wb_rd_data : rf_rs1_data);
  assign op2 = (id_rs2_idx == '0) ? '0 : (fwd2 ? wb_rd_data : rf_rs2_data);

  // A busy source is fine when its writeback lands this same cycle.
  assign haz1 = id_rs1_en && (id_rs1_idx != '0) && busy[id_rs1_idx] && !fwd1;
  assign haz2 = id_rs2_en && (id_rs2_idx != '0) && busy[id_rs2_idx] && !fwd2;

  // WAW: the older write to rd must retire first, unless it retires now.
  assign wb_hits_rd = wb_we && (wb_rd_idx == id_rd_idx);
  assign haz_w = id_rd_we && (id_rd_idx != '0) && busy[id_rd_idx] && !wb_hits_rd;

  assign id_ready = (!ex_valid || ex_ready) && !haz1 && !haz2 && !haz_w && !flush;
  assign accept   = id_valid && id_ready;

  assign ex_valid = (state == SLOT_FULL);
  assign dbg_busy = busy;

  // Clear first, then set, so a new writer of the index being retired this
  // cycle keeps its busy bit.
  always_comb begin
    busy_nxt = busy;
    if (wb_we) begin
      busy_nxt[wb_rd_idx] = 1'b0;
    end
    if (accept && id_rd_we && (id_rd_idx != '0)) begin
      busy_nxt[id_rd_idx] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SLOT_EMPTY;
      busy        <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd_idx   <= '0;
      ex_rd_we    <= 1'b0;
      ex_imm      <= '0;
      ex_op       <= '0;
    end else if (flush) begin
      // Everything downstream is squashed with us, so no pending write survives.
      state <= SLOT_EMPTY;
      busy  <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        state       <= SLOT_FULL;
        ex_rs1_data <= op1;
        ex_rs2_data <= op2;
        ex_rd_idx   <= id_rd_idx;
        ex_rd_we    <= id_rd_we;
        ex_imm      <= id_imm;
        ex_op       <= id_op;
      end else if (ex_ready) begin
        state <= SLOT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 3;
  localparam int OP_W      = 6;
  localparam int PKT_W     = 2 * XLEN + REG_IDX_W + 1 + XLEN + OP_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 id_valid, id_ready;
  logic [REG_IDX_W-1:0] id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic                 id_rs1_en, id_rs2_en, id_rd_we;
  logic [XLEN-1:0]      id_imm;
  logic [OP_W-1:0]      id_op;
  logic [REG_IDX_W-1:0] rf_rs1_idx, rf_rs2_idx;
  logic [XLEN-1:0]      rf_rs1_data, rf_rs2_data;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd_idx;
  logic [XLEN-1:0]      wb_rd_data;
  logic                 flush;
  logic                 ex_valid, ex_ready;
  logic [XLEN-1:0]      ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_IDX_W-1:0] ex_rd_idx;
  logic                 ex_rd_we;
  logic [OP_W-1:0]      ex_op;
  logic [7:0]           dbg_busy;

  operand_fetch #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_idx(id_rs1_idx), .id_rs1_en(id_rs1_en),
    .id_rs2_idx(id_rs2_idx), .id_rs2_en(id_rs2_en),
    .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we),
    .id_imm(id_imm), .id_op(id_op),
    .rf_rs1_idx(rf_rs1_idx), .rf_rs1_data(rf_rs1_data),
    .rf_rs2_idx(rf_rs2_idx), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_rd_idx(wb_rd_idx), .wb_rd_data(wb_rd_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd_idx(ex_rd_idx), .ex_rd_we(ex_rd_we),
    .ex_imm(ex_imm), .ex_op(ex_op),
    .dbg_busy(dbg_busy)
  );

  // Regfile stub: combinational read, written #1 after the edge by step().
  logic [XLEN-1:0] rf_mem [8];
  assign rf_rs1_data = rf_mem[rf_rs1_idx];
  assign rf_rs2_data = rf_mem[rf_rs2_idx];

  // ---------------- scoreboard / model state ----------------
  logic [PKT_W-1:0] exp_q[$];
  logic             m_full;
  logic [7:0]       m_busy;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_busy = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_valid   = 1'b0;
    id_rs1_idx = '0; id_rs1_en = 1'b0;
    id_rs2_idx = '0; id_rs2_en = 1'b0;
    id_rd_idx  = '0; id_rd_we  = 1'b0;
    id_imm     = '0; id_op     = '0;
    wb_we      = 1'b0; wb_rd_idx = '0; wb_rd_data = '0;
    flush      = 1'b0;
    ex_ready   = 1'b1;
  endtask

  task automatic issue(input logic [2:0] rs1, input logic en1, input logic [2:0] rs2,
                       input logic en2, input logic [2:0] rd, input logic we,
                       input logic [31:0] imm, input logic [5:0] op);
    id_valid   = 1'b1;
    id_rs1_idx = rs1; id_rs1_en = en1;
    id_rs2_idx = rs2; id_rs2_en = en2;
    id_rd_idx  = rd;  id_rd_we  = we;
    id_imm     = imm; id_op     = op;
  endtask

  task automatic wb(input logic we, input logic [2:0] idx, input logic [31:0] data);
    wb_we = we; wb_rd_idx = idx; wb_rd_data = data;
  endtask

  // One cycle: called just after a negedge with inputs already driven.
  // Predicts id_ready and the captured packet, then checks the slot after the edge.
  task automatic step();
    logic            f1, f2, h1, h2, hw, rdy, acc;
    logic [XLEN-1:0] o1, o2;
    logic [PKT_W-1:0] front;
    #1;
    f1  = wb_we && (wb_rd_idx != 0) && (wb_rd_idx == id_rs1_idx);
    f2  = wb_we && (wb_rd_idx != 0) && (wb_rd_idx == id_rs2_idx);
    o1  = (id_rs1_idx == 0) ? '0 : (f1 ? wb_rd_data : rf_mem[id_rs1_idx]);
    o2  = (id_rs2_idx == 0) ? '0 : (f2 ? wb_rd_data : rf_mem[id_rs2_idx]);
    h1  = id_rs1_en && (id_rs1_idx != 0) && m_busy[id_rs1_idx] && !f1;
    h2  = id_rs2_en && (id_rs2_idx != 0) && m_busy[id_rs2_idx] && !f2;
    hw  = id_rd_we && (id_rd_idx != 0) && m_busy[id_rd_idx] && !(wb_we && (wb_rd_idx == id_rd_idx));
    rdy = (!m_full || ex_ready) && !h1 && !h2 && !hw && !flush;
    acc = id_valid && rdy;
    check("id_ready", id_ready, rdy);
    check("rf_rs1_idx", rf_rs1_idx, id_rs1_idx);
    if (flush) begin
      model_reset();
    end else begin
      if (m_full && ex_ready) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({o1, o2, id_rd_idx, id_rd_we, id_imm, id_op});
      m_full = acc || (m_full && !ex_ready);
      if (wb_we) m_busy[wb_rd_idx] = 1'b0;
      if (acc && id_rd_we && (id_rd_idx != 0)) m_busy[id_rd_idx] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (wb_we && (wb_rd_idx != 0)) rf_mem[wb_rd_idx] = wb_rd_data;
    check("ex_valid", ex_valid, m_full);
    check("busy", dbg_busy, m_busy);
    if (m_full && exp_q.size() > 0) begin
      front = exp_q[0];
      check("ex_rs1_data", ex_rs1_data, front[PKT_W-1 -: XLEN]);
      check("ex_rs2_data", ex_rs2_data, front[PKT_W-1-XLEN -: XLEN]);
      check("ex_rd_idx",   ex_rd_idx,   front[XLEN+OP_W+1 +: REG_IDX_W]);
      check("ex_rd_we",    ex_rd_we,    front[XLEN+OP_W]);
      check("ex_imm",      ex_imm,      front[OP_W +: XLEN]);
      check("ex_op",       ex_op,       front[OP_W-1:0]);
    end else if (m_full) begin
      check("exp_q_nonempty", 64'(exp_q.size()), 64'd1);
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = '0;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_busy", dbg_busy, 8'h00);
    check("rst_ex_rs1", ex_rs1_data, 32'h0);
    check("rst_ex_op", ex_op, 6'h0);
    rst_n = 1'b1;
    step();   // idle after release: id_ready must be 1

    // Preload r3/r5 through the writeback port.
    wb(1'b1, 3'd3, 32'h11); step();
    wb(1'b1, 3'd5, 32'h22); step();
    wb(1'b0, 3'd0, 32'h0);

    // Pass-through.
    issue(3'd3, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 32'h7, 6'h0A);
    step();
    check("pt_valid", ex_valid, 1'b1);
    check("pt_rs1", ex_rs1_data, 32'h11);
    check("pt_rs2", ex_rs2_data, 32'h22);
    check("pt_rd", ex_rd_idx, 3'd6);
    check("pt_op", ex_op, 6'h0A);
    check("pt_imm", ex_imm, 32'h7);

    // Asynchronous reset while FULL with busy[6] set.
    id_valid = 1'b0; ex_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", ex_valid, 1'b0);
    check("async_rst_busy", dbg_busy, 8'h00);
    check("async_rst_rs1", ex_rs1_data, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    step();

    // RAW stall, then forward on the writeback cycle.
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 32'h0, 6'h01);
    step();
    issue(3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0, 6'h02);
    #1 check("raw_stall", id_ready, 1'b0);
    step();
    step();
    wb(1'b1, 3'd2, 32'hDEAD);
    #1 check("raw_release", id_ready, 1'b1);
    step();
    check("raw_fwd", ex_rs1_data, 32'hDEAD);
    wb(1'b0, 3'd0, 32'h0);

    // Backpressure: slot FULL, execute stalls for 5 cycles.
    ex_ready = 1'b0;
    issue(3'd3, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 32'h55, 6'h03);
    for (int i = 0; i < 5; i++) step();
    check("bp_hold_rs1", ex_rs1_data, 32'hDEAD);
    check("bp_hold_busy", dbg_busy, 8'h00);
    ex_ready = 1'b1;
    step();
    check("bp_accept_rs1", ex_rs1_data, 32'h11);
    issue(3'd5, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 32'h66, 6'h04);
    step();
    check("bp_b2b_rs1", ex_rs1_data, 32'h22);
    id_valid = 1'b0;
    step();
    flush = 1'b1; step(); flush = 1'b0;

    // r0 handling and set/clear collision.
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 32'h0, 6'h05);
    step();
    check("r0_no_busy", dbg_busy, 8'h00);
    issue(3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 32'h0, 6'h06);
    wb(1'b1, 3'd0, 32'hFFFFFFFF);
    step();
    check("r0_reads_zero", ex_rs1_data, 32'h0);
    wb(1'b0, 3'd0, 32'h0);
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 32'h0, 6'h07);
    step();
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 32'h0, 6'h08);
    wb(1'b1, 3'd4, 32'h44);
    step();
    check("collide_set_wins", dbg_busy[4], 1'b1);
    wb(1'b0, 3'd0, 32'h0);
    id_valid = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;

    // Flush with busy {1,3} and the slot FULL.
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 32'h0, 6'h09);
    step();
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 32'h0, 6'h0B);
    step();
    check("fl_busy_before", dbg_busy, 8'h0A);
    ex_ready = 1'b0;
    issue(3'd2, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 32'h0, 6'h0C);
    wb(1'b1, 3'd1, 32'h99);
    flush = 1'b1;
    #1 check("fl_id_ready", id_ready, 1'b0);
    step();
    check("fl_valid", ex_valid, 1'b0);
    check("fl_busy", dbg_busy, 8'h00);
    idle_inputs();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom(), 6'($urandom_range(0, 63)));
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      wb(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom());
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
